// File: rtl/cpu_ctrl_pkg.sv
// Shared control-path types and constants for the pipeline hazard/sequencing logic
// and the D/X pipeline register.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2,
    MEM_WAIT   = 2'd3
  } hz_state_t;

  localparam int REG_ZERO = 0;

  // D/X control-field layout; dx_bubble zeroes all of these
  localparam int DX_CTRL_W      = 4;
  localparam int DX_MEM_READ    = 0;
  localparam int DX_MEM_WRITE   = 1;
  localparam int DX_JUMP        = 2;
  localparam int DX_REG_WRITE   = 3;

  typedef struct packed {
    logic pc_write;
    logic fd_write;
    logic fd_flush;
    logic dx_write;
    logic dx_bubble;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTL_RUN    = 5'b11010;
  localparam hz_ctrl_t CTL_STALL  = 5'b00011;
  localparam hz_ctrl_t CTL_FLUSH  = 5'b11111;
  localparam hz_ctrl_t CTL_FREEZE = 5'b00000;
  localparam hz_ctrl_t CTL_RESET  = 5'b00001;

endpackage

// File: rtl/hazard_compare.sv
// Load-use match between a producer in a later stage and the Decode sources.
module hazard_compare
  import cpu_ctrl_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              src_read,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic              uses_rt,
  output logic              hz
);

  assign hz = src_read & (src_addr != ADDR_W'(REG_ZERO)) &
              ((src_addr == rs_addr) | (uses_rt & (src_addr == rt_addr)));

endmodule

// File: rtl/dx_hazard_controller.sv
// D/X hazard sequencer: load-use bubbles, jump flushes, memory-busy freeze.
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module dx_hazard_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int ADDR_W       = 5,
  parameter int LOAD_BUBBLES = 1,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] d_rs_addr,
  input  logic [ADDR_W-1:0] d_rt_addr,
  input  logic              d_uses_rt,
  input  logic              x_mem_read,
  input  logic [ADDR_W-1:0] x_rt_addr,
  input  logic              x_jump,
  input  logic              mem_busy,
  output logic              pc_write,
  output logic              fd_write,
  output logic              fd_flush,
  output logic              dx_write,
  output logic              dx_bubble,
  output logic              stalled
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_cycles
`endif
);

  hz_state_t state, state_nxt, resume, resume_nxt, eff;
  logic [1:0] cnt, cnt_nxt;
  logic       hz;
  hz_ctrl_t   ctl;

  hazard_compare #(.ADDR_W(ADDR_W)) u_cmp (
    .src_read (x_mem_read),
    .src_addr (x_rt_addr),
    .rs_addr  (d_rs_addr),
    .rt_addr  (d_rt_addr),
    .uses_rt  (d_uses_rt),
    .hz       (hz)
  );

  // Leaving MEM_WAIT behaves exactly like the state that was frozen
  assign eff = (state == MEM_WAIT) ? resume : state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      resume <= RUN;
      cnt    <= 2'd0;
    end else begin
      state  <= state_nxt;
      resume <= resume_nxt;
      cnt    <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    resume_nxt = resume;
    cnt_nxt    = cnt;
    if (mem_busy) begin
      state_nxt = MEM_WAIT;
      if (state != MEM_WAIT) resume_nxt = state;
    end else begin
      case (eff)
        RUN: begin
          state_nxt = RUN;
          if (x_jump) begin
            if (FLUSH_CYCLES > 1) begin
              state_nxt = FLUSH;
              cnt_nxt   = 2'(FLUSH_CYCLES - 1);
            end
          end else if (hz) begin
            if (LOAD_BUBBLES > 1) begin
              state_nxt = LOAD_STALL;
              cnt_nxt   = 2'(LOAD_BUBBLES - 1);
            end
          end
        end
        LOAD_STALL: begin
          cnt_nxt   = cnt - 2'd1;
          state_nxt = (cnt <= 2'd1) ? RUN : LOAD_STALL;
        end
        FLUSH: begin
          cnt_nxt   = cnt - 2'd1;
          state_nxt = (cnt <= 2'd1) ? RUN : FLUSH;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_comb begin
    ctl = CTL_RUN;
    if (!rst_n)        ctl = CTL_RESET;
    else if (mem_busy) ctl = CTL_FREEZE;
    else begin
      case (eff)
        RUN:        ctl = x_jump ? CTL_FLUSH : (hz ? CTL_STALL : CTL_RUN);
        LOAD_STALL: ctl = CTL_STALL;  // load already advanced; no hz re-check
        FLUSH:      ctl = CTL_FLUSH;
        default:    ctl = CTL_RUN;
      endcase
    end
  end

  assign pc_write  = ctl.pc_write;
  assign fd_write  = ctl.fd_write;
  assign fd_flush  = ctl.fd_flush;
  assign dx_write  = ctl.dx_write;
  assign dx_bubble = ctl.dx_bubble;
  assign stalled   = ~ctl.pc_write;

`ifdef HAZARD_PERF_CNT_EN
  logic stall_evt;
  assign stall_evt = ~ctl.pc_write | (state == MEM_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= 32'd0;
      flush_cycles <= 32'd0;
    end else begin
      if (stall_evt)    stall_cycles <= stall_cycles + 32'd1;
      if (ctl.fd_flush) flush_cycles <= flush_cycles + 32'd1;
    end
  end
`endif

endmodule
